// File: rtl/pci_pkg.sv
// Shared constants and elaboration-time helpers for the lane serializer datapath.
package pci_pkg;

  localparam logic [7:0] IDLE_DEFAULT = 8'hBC;

  function automatic int clog2(input int value);
    int result;
    int span;
    result = 32'sd0;
    span   = 32'sd1;
    for (int i = 0; i < 31; i++) begin
      if (span < value) begin
        span   = span * 32'sd2;
        result = result + 32'sd1;
      end else begin
        result = result;
      end
    end
    return result;
  endfunction

  // Lane-index width; a 1-bit field is kept even for degenerate lane counts.
  function automatic int lw(input int lanes);
    int bits;
    bits = clog2(lanes);
    return (bits < 32'sd1) ? 32'sd1 : bits;
  endfunction

endpackage

// File: rtl/lane_fifo.sv
// Per-lane synchronous FIFO; extra pointer bit distinguishes full from empty.
module lane_fifo
  import pci_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] dataIn,
  output logic [WIDTH-1:0] dataOut,
  output logic             full,
  output logic             empty
);

  localparam int AW = clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [PW-1:0]    wrPtr_r;
  logic [PW-1:0]    rdPtr_r;
  logic [PW-1:0]    count_s;
  logic             pushOk_s;
  logic             popOk_s;

  assign count_s  = wrPtr_r - rdPtr_r;
  assign full     = (count_s == PW'(DEPTH));
  assign empty    = (count_s == {PW{1'b0}});
  assign pushOk_s = push && !full;
  assign popOk_s  = pop && !empty;
  assign dataOut  = mem_r[rdPtr_r[AW-1:0]];

  // Pointer registers; a write into a full FIFO is ignored here and flagged upstream.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wrPtr_r <= {PW{1'b0}};
      rdPtr_r <= {PW{1'b0}};
    end else begin
      wrPtr_r <= pushOk_s ? (wrPtr_r + PW'(1)) : wrPtr_r;
      rdPtr_r <= popOk_s  ? (rdPtr_r + PW'(1)) : rdPtr_r;
    end
  end

  // Storage array; contents need no reset because the pointers gate every read.
  always_ff @(posedge clk) begin
    if (pushOk_s) begin
      mem_r[wrPtr_r[AW-1:0]] <= dataIn;
    end else begin
      mem_r[wrPtr_r[AW-1:0]] <= mem_r[wrPtr_r[AW-1:0]];
    end
  end

endmodule

// File: rtl/lane_serializer_rr.sv
// N-lane to 1-stream serializer: per-lane FIFOs merged round-robin onto a
// registered valid/ready output, in compress or fixed-slot mode.
module lane_serializer_rr
  import pci_pkg::*;
#(
  parameter int               WIDTH = 8,
  parameter int               LANES = 4,
  parameter int               DEPTH = 4,
  parameter logic [WIDTH-1:0] IDLE  = WIDTH'(IDLE_DEFAULT)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [LANES*WIDTH-1:0] data_in,
  input  logic [LANES-1:0]       valid_in,
  output logic [LANES-1:0]       ready_in,
  input  logic                   compress,
  output logic [WIDTH-1:0]       data_out,
  output logic                   valid_out,
  output logic [lw(LANES)-1:0]   lane_out,
  input  logic                   ready_out,
  output logic [LANES-1:0]       overflow
);

  localparam int LW = lw(LANES);

  logic [LANES-1:0] fullVec_s;
  logic [LANES-1:0] emptyVec_s;
  logic [LANES-1:0] popVec_s;
  logic [WIDTH-1:0] fifoData_s [LANES];

  logic [LW-1:0]    ptr_r;
  logic [LW-1:0]    ptrNext_s;
  logic [LW-1:0]    selLane_s;
  logic             found_s;
  logic             adv_s;
  logic [WIDTH-1:0] dataNext_s;
  logic             validNext_s;
  logic [LW-1:0]    laneNext_s;

  function automatic logic [LW-1:0] incLane(input logic [LW-1:0] lane);
    if (lane == LW'(LANES - 1)) begin
      return {LW{1'b0}};
    end else begin
      return lane + LW'(1);
    end
  endfunction

  for (genvar i = 0; i < LANES; i++) begin : laneGen
    lane_fifo #(
      .WIDTH(WIDTH),
      .DEPTH(DEPTH)
    ) uFifo (
      .clk    (clk),
      .reset  (reset),
      .push   (valid_in[i]),
      .pop    (popVec_s[i]),
      .dataIn (data_in[i*WIDTH +: WIDTH]),
      .dataOut(fifoData_s[i]),
      .full   (fullVec_s[i]),
      .empty  (emptyVec_s[i])
    );
  end

  assign ready_in = ~fullVec_s;
  assign adv_s    = !valid_out || ready_out;

  // Compress-mode search: first non-empty lane at or after the pointer, wrapping.
  always_comb begin
    found_s   = 1'b0;
    selLane_s = ptr_r;
    for (int k = 0; k < LANES; k++) begin
      if (!found_s && !emptyVec_s[(int'(ptr_r) + k) % LANES]) begin
        found_s   = 1'b1;
        selLane_s = LW'((int'(ptr_r) + k) % LANES);
      end else begin
        found_s = found_s;
      end
    end
  end

  // Next output word, lane tag, pop request and pointer; everything holds when not advancing.
  always_comb begin
    popVec_s    = {LANES{1'b0}};
    dataNext_s  = data_out;
    validNext_s = valid_out;
    laneNext_s  = lane_out;
    ptrNext_s   = ptr_r;
    if (adv_s) begin
      if (compress) begin
        if (found_s) begin
          popVec_s[selLane_s] = 1'b1;
          dataNext_s          = fifoData_s[selLane_s];
          validNext_s         = 1'b1;
          laneNext_s          = selLane_s;
          ptrNext_s           = incLane(selLane_s);
        end else begin
          validNext_s = 1'b0;
        end
      end else begin
        laneNext_s = ptr_r;
        ptrNext_s  = incLane(ptr_r);
        if (!emptyVec_s[ptr_r]) begin
          popVec_s[ptr_r] = 1'b1;
          dataNext_s      = fifoData_s[ptr_r];
          validNext_s     = 1'b1;
        end else begin
          dataNext_s  = IDLE;
          validNext_s = 1'b0;
        end
      end
    end else begin
      popVec_s = {LANES{1'b0}};
    end
  end

  // Output register and round-robin pointer.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      data_out  <= {WIDTH{1'b0}};
      valid_out <= 1'b0;
      lane_out  <= {LW{1'b0}};
      ptr_r     <= {LW{1'b0}};
    end else begin
      data_out  <= dataNext_s;
      valid_out <= validNext_s;
      lane_out  <= laneNext_s;
      ptr_r     <= ptrNext_s;
    end
  end

  // Sticky drop flags: a request against a full lane is lost and remembered until reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      overflow <= {LANES{1'b0}};
    end else begin
      overflow <= overflow | (valid_in & fullVec_s);
    end
  end

endmodule

// File: tb/tb_lane_serializer_rr.sv
// Self-checking bench for lane_serializer_rr: directed vector table, corner
// sequences and a randomized run against a queue-based reference model.
module tb_lane_serializer_rr;

  localparam int WIDTH = 8;
  localparam int LANES = 4;
  localparam int DEPTH = 4;

  logic        clk;
  logic        reset;
  logic [31:0] data_in;
  logic [3:0]  valid_in;
  logic [3:0]  ready_in;
  logic        compress;
  logic [7:0]  data_out;
  logic        valid_out;
  logic [1:0]  lane_out;
  logic        ready_out;
  logic [3:0]  overflow;

  int checks = 0;
  int errors = 0;

  logic [7:0] mq [4][$];
  logic [7:0] mData;
  logic       mValid;
  int         mLane;
  int         mPtr;
  logic [3:0] mOvf;

  typedef struct {
    logic [3:0]  vin;
    logic [31:0] din;
    logic        cmp;
    logic        rdy;
    logic        ev;
    logic [7:0]  ed;
    logic [1:0]  el;
  } vec_t;

  vec_t vecs [13];

  lane_serializer_rr #(
    .WIDTH(WIDTH),
    .LANES(LANES),
    .DEPTH(DEPTH),
    .IDLE (8'hBC)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .data_in  (data_in),
    .valid_in (valid_in),
    .ready_in (ready_in),
    .compress (compress),
    .data_out (data_out),
    .valid_out(valid_out),
    .lane_out (lane_out),
    .ready_out(ready_out),
    .overflow (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic modelReset();
    for (int i = 0; i < 4; i++) mq[i].delete();
    mData  = 8'h00;
    mValid = 1'b0;
    mLane  = 0;
    mPtr   = 0;
    mOvf   = 4'b0000;
  endtask

  // One clock: apply the behavioural rules to the model, take the edge, compare.
  task automatic cycle();
    bit   full [4];
    bit   ne [4];
    bit   adv;
    bit   found;
    int   s;
    logic [3:0] expRdy;
    for (int i = 0; i < 4; i++) begin
      full[i] = (mq[i].size() == DEPTH);
      ne[i]   = (mq[i].size() != 0);
    end
    adv = !mValid || ready_out;
    if (adv) begin
      if (compress) begin
        found = 0;
        s = 0;
        for (int k = 0; k < 4; k++) begin
          if (!found && ne[(mPtr + k) % 4]) begin
            found = 1;
            s = (mPtr + k) % 4;
          end
        end
        if (found) begin
          mData  = mq[s].pop_front();
          mValid = 1'b1;
          mLane  = s;
          mPtr   = (s + 1) % 4;
        end else begin
          mValid = 1'b0;
        end
      end else begin
        mLane = mPtr;
        if (ne[mPtr]) begin
          mData  = mq[mPtr].pop_front();
          mValid = 1'b1;
        end else begin
          mData  = 8'hBC;
          mValid = 1'b0;
        end
        mPtr = (mPtr + 1) % 4;
      end
    end
    for (int i = 0; i < 4; i++) begin
      if (valid_in[i]) begin
        if (full[i]) mOvf[i] = 1'b1;
        else mq[i].push_back(data_in[i*8 +: 8]);
      end
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) expRdy[i] = (mq[i].size() != DEPTH);
    chk("model_valid_out", valid_out, mValid);
    chk("model_data_out", data_out, mData);
    chk("model_lane_out", lane_out, mLane);
    chk("model_ready_in", ready_in, expRdy);
    chk("model_overflow", overflow, mOvf);
  endtask

  initial begin
    int       nLane1;
    logic [7:0] got [$];

    vecs[0]  = '{vin: 4'b1111, din: 32'hCCDDEEFF, cmp: 1'b1, rdy: 1'b1, ev: 1'b0, ed: 8'h00, el: 2'd0};
    vecs[1]  = '{vin: 4'b0000, din: 32'h00000000, cmp: 1'b1, rdy: 1'b1, ev: 1'b1, ed: 8'hFF, el: 2'd0};
    vecs[2]  = '{vin: 4'b0000, din: 32'h00000000, cmp: 1'b1, rdy: 1'b1, ev: 1'b1, ed: 8'hEE, el: 2'd1};
    vecs[3]  = '{vin: 4'b0000, din: 32'h00000000, cmp: 1'b1, rdy: 1'b1, ev: 1'b1, ed: 8'hDD, el: 2'd2};
    vecs[4]  = '{vin: 4'b0000, din: 32'h00000000, cmp: 1'b1, rdy: 1'b1, ev: 1'b1, ed: 8'hCC, el: 2'd3};
    vecs[5]  = '{vin: 4'b0000, din: 32'h00000000, cmp: 1'b1, rdy: 1'b1, ev: 1'b0, ed: 8'hCC, el: 2'd3};
    vecs[6]  = '{vin: 4'b0100, din: 32'h00770000, cmp: 1'b0, rdy: 1'b1, ev: 1'b0, ed: 8'hBC, el: 2'd0};
    vecs[7]  = '{vin: 4'b0000, din: 32'h00000000, cmp: 1'b0, rdy: 1'b1, ev: 1'b0, ed: 8'hBC, el: 2'd1};
    vecs[8]  = '{vin: 4'b0000, din: 32'h00000000, cmp: 1'b0, rdy: 1'b1, ev: 1'b1, ed: 8'h77, el: 2'd2};
    vecs[9]  = '{vin: 4'b0000, din: 32'h00000000, cmp: 1'b0, rdy: 1'b1, ev: 1'b0, ed: 8'hBC, el: 2'd3};
    vecs[10] = '{vin: 4'b0100, din: 32'h00770000, cmp: 1'b1, rdy: 1'b1, ev: 1'b0, ed: 8'hBC, el: 2'd3};
    vecs[11] = '{vin: 4'b0000, din: 32'h00000000, cmp: 1'b1, rdy: 1'b1, ev: 1'b1, ed: 8'h77, el: 2'd2};
    vecs[12] = '{vin: 4'b0000, din: 32'h00000000, cmp: 1'b1, rdy: 1'b1, ev: 1'b0, ed: 8'h77, el: 2'd2};

    // Reset and idle.
    reset     = 1'b0;
    data_in   = 32'h0;
    valid_in  = 4'b0000;
    compress  = 1'b1;
    ready_out = 1'b1;
    modelReset();
    #12;
    chk("rst_data_out", data_out, 8'h00);
    chk("rst_valid_out", valid_out, 1'b0);
    chk("rst_lane_out", lane_out, 2'd0);
    chk("rst_overflow", overflow, 4'b0000);
    chk("rst_ready_in", ready_in, 4'b1111);
    #4;
    reset = 1'b1;
    for (int n = 0; n < 3; n++) begin
      cycle();
      chk("idle_valid_out", valid_out, 1'b0);
    end

    // Directed table: round-robin burst, then sparse lane in fixed and compress modes.
    for (int v = 0; v < 13; v++) begin
      valid_in  = vecs[v].vin;
      data_in   = vecs[v].din;
      compress  = vecs[v].cmp;
      ready_out = vecs[v].rdy;
      cycle();
      chk($sformatf("vec%0d_valid", v), valid_out, vecs[v].ev);
      chk($sformatf("vec%0d_data", v), data_out, vecs[v].ed);
      chk($sformatf("vec%0d_lane", v), lane_out, vecs[v].el);
    end

    // Backpressure: BB held for three stalled cycles, then AA and 99 in order.
    valid_in = 4'b0111; data_in = 32'h0099AABB; compress = 1'b1; ready_out = 1'b1;
    cycle();
    valid_in = 4'b0000; ready_out = 1'b0;
    cycle();
    chk("bp_load_data", data_out, 8'hBB);
    chk("bp_load_valid", valid_out, 1'b1);
    for (int n = 0; n < 3; n++) begin
      cycle();
      chk("bp_hold_data", data_out, 8'hBB);
      chk("bp_hold_valid", valid_out, 1'b1);
    end
    ready_out = 1'b1;
    cycle();
    chk("bp_next_aa", data_out, 8'hAA);
    cycle();
    chk("bp_next_99", data_out, 8'h99);
    chk("bp_next_99_lane", lane_out, 2'd2);
    cycle();
    chk("bp_drained", valid_out, 1'b0);

    // Overflow: stall the output, then write five words to lane 1.
    ready_out = 1'b0; valid_in = 4'b0001; data_in = 32'h00000010;
    cycle();
    valid_in = 4'b0000;
    cycle();
    chk("ovf_stall_valid", valid_out, 1'b1);
    for (int n = 0; n < 5; n++) begin
      valid_in = 4'b0010;
      data_in  = {16'h0000, 8'h21 + 8'(n), 8'h00};
      cycle();
      chk($sformatf("ovf_ready_in1_w%0d", n + 1), ready_in[1], (n < 3) ? 1'b1 : 1'b0);
    end
    chk("ovf_flag_set", overflow[1], 1'b1);
    valid_in = 4'b0000; ready_out = 1'b1;
    for (int n = 0; n < 8; n++) begin
      cycle();
      if (valid_out && lane_out == 2'd1) got.push_back(data_out);
    end
    nLane1 = got.size();
    chk("ovf_drain_count", nLane1, 4);
    for (int n = 0; n < 4 && n < nLane1; n++) chk("ovf_drain_word", got[n], 8'h21 + 8'(n));
    chk("ovf_flag_sticky", overflow[1], 1'b1);

    // Asynchronous reset with words buffered.
    ready_out = 1'b0; valid_in = 4'b1111; data_in = 32'h44332211;
    cycle();
    valid_in = 4'b0000;
    cycle();
    chk("mr_loaded_valid", valid_out, 1'b1);
    #2;
    reset = 1'b0;
    #1;
    chk("mr_async_valid", valid_out, 1'b0);
    chk("mr_async_data", data_out, 8'h00);
    chk("mr_async_ready_in", ready_in, 4'b1111);
    chk("mr_async_overflow", overflow, 4'b0000);
    modelReset();
    @(negedge clk);
    reset = 1'b1;
    ready_out = 1'b1;
    for (int n = 0; n < 5; n++) begin
      cycle();
      chk("mr_no_stale", valid_out, 1'b0);
    end

    // Randomized traffic against the reference model.
    for (int n = 0; n < 600; n++) begin
      if (n % 40 == 0) compress = 1'($urandom_range(0, 1));
      valid_in  = 4'($urandom_range(0, 15));
      data_in   = $urandom;
      ready_out = ((n / 100) % 2 == 0) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/lane_serializer_rr.md
# lane_serializer_rr

Parametrised N-lane to 1-stream serializer for the PCI physical-layer datapath, successor to the fixed 4-lane, multi-clock selector muxing. Each input lane is buffered in its own FIFO. A round-robin scheduler merges the lanes onto one registered output stream with a lane tag. It runs on a single clock with a valid/ready output handshake and has two modes: compress (skip empty lanes) and fixed-slot (emit an idle word for empty lanes).

## Interface
Parameters:
- WIDTH, 8, bits per data word
- LANES, 4, number of input lanes (>= 2)
- DEPTH, 4, words per lane FIFO (power of 2, >= 2)
- IDLE, 8'hBC, word emitted in fixed-slot mode for an empty lane (WIDTH bits)

Ports:
- clk  in  1  single clock; all state changes on posedge
- reset  in  1  asynchronous, active-low; clears all state immediately, release synchronous to clk
- data_in  in  LANES*WIDTH  lane i occupies bits [i*WIDTH +: WIDTH]
- valid_in  in  LANES  per-lane write request
- ready_in  out  LANES  per-lane FIFO not full
- compress  in  1  1 = skip empty lanes, 0 = fixed-slot mode
- data_out  out  WIDTH  registered output word
- valid_out  out  1  data_out carries a real lane word
- lane_out  out  LW  source lane of data_out, where LW = max(1, clog2(LANES))
- ready_out  in  1  downstream accepts the word
- overflow  out  LANES  sticky per-lane drop flag

## Operation
Lane FIFOs:
- A write occurs when valid_in[i] && ready_in[i].
- ready_in[i] = !full[i], computed from the occupancy at the start of the cycle, independent of a same-cycle pop.
- valid_in[i] while full[i]: the word is dropped and overflow[i] is set. The flag holds until reset.
- A simultaneous push and pop on a non-full FIFO leaves the count unchanged.
- Pointers are log2(DEPTH)+1 bits and wrap naturally.

Output stage:
- The stage advances when adv = !valid_out || ready_out.
- When adv is 0, data_out, valid_out and lane_out hold stable.

Scheduler:
- Holds a round-robin pointer ptr with range 0..LANES-1.
- Compress mode, on adv:
  - Select the first non-empty lane s, searching ptr, ptr+1, ... modulo LANES.
  - Pop it, load data_out, set lane_out = s, valid_out = 1, and ptr = (s+1) mod LANES.
  - If all lanes are empty: valid_out = 0, data_out and lane_out hold, ptr unchanged.
- Fixed-slot mode, on adv:
  - lane_out = ptr.
  - If lane ptr is non-empty: pop it, load its word, valid_out = 1.
  - Otherwise: data_out = IDLE, valid_out = 0.
  - ptr advances by 1 mod LANES every adv.
- compress is sampled on each adv edge. Changing it mid-stream loses no buffered data and leaves ptr unchanged.
- At most one pop per cycle in total.

Reset values:
- data_out = 0, valid_out = 0, lane_out = 0, overflow = 0
- ptr = 0, all FIFOs empty, ready_in = all ones
- Reset asserted mid-operation discards all buffered words.

## Timing
- Latency: a word written at edge k can appear on data_out after edge k+1 (2-cycle minimum, input to output).
- Throughput: one word per cycle while ready_out = 1.
- Fairness (compress mode): with all lanes continuously non-empty, the output order is strictly 0,1,...,LANES-1 repeating.
- Boundary cases:
  - Full lane: ready_in is low in the same cycle as the 4th write completes (DEPTH = 4).
  - Empty lane: it cannot be popped in the same cycle it is written.
  - Backpressure (ready_out = 0 with valid_out = 1): no pops, ptr frozen, output held.

## Structure
- Package pci_pkg holds:
  - default IDLE constant
  - a clog2 helper function
  - the lane-index width function LW
- Sub-module lane_fifo is a synchronous FIFO (WIDTH x DEPTH) with push, pop, full, empty and async active-low reset. It is instantiated LANES times from a generate loop.
- The top level contains the scheduler, the output register and the overflow flags.

## Test plan
- Reset/idle:
  - Stimulus: hold reset low, then release it with no input.
  - Required: all outputs at their reset values, ready_in = 4'b1111, valid_out stays 0 in compress mode.
- Round-robin burst, compress mode:
  - Stimulus: one cycle with all lanes valid, words FF, EE, DD, CC; ready_out = 1.
  - Required: outputs FF/0, EE/1, DD/2, CC/3 (word/lane) on consecutive cycles, first word 2 cycles after the write.
- Sparse lanes, compress vs fixed:
  - Stimulus: only lane 2 writes 77.
  - Compress mode required: 77 with lane_out = 2, then valid_out = 0.
  - Fixed mode (ptr = 0) required: BC/0 and BC/1 with valid_out = 0, then 77/2 with valid_out = 1, then BC/3.
- Backpressure:
  - Stimulus: ready_out = 0 for 3 cycles while valid_out = 1 with BB.
  - Required: data_out stays BB; the next words AA, 99 follow in order after release, with none lost or duplicated.
- Overflow:
  - Stimulus: with ready_out = 0, write 5 words to lane 1.
  - Required: ready_in[1] drops after the 4th write, the 5th word is dropped, overflow[1] = 1 and stays 1, and exactly 4 words are drained.
- Mid-operation reset:
  - Stimulus: assert reset asynchronously with 3 words buffered.
  - Required: valid_out = 0 immediately with no clock, and no stale words appear after release.
